frame_capture_ctrl: RTL and testbench

//  Sequences single-frame capture of the processed video stream into the 8-bit (RGB332) frame BRAM.

---
 rtl/frame_capture_ctrl_pkg.sv | 20 ++
 rtl/fb_addr_gen.sv | 45 ++++
 rtl/frame_capture_ctrl.sv | 120 ++++++++++++
 tb/tb_frame_capture_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_capture_ctrl_pkg.sv
// rtl/frame_capture_ctrl_pkg.sv - shared geometry defaults, capture FSM states and RGB332 packing
package frame_capture_ctrl_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 400;
   localparam int ADDR_W_DEF   = 18;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } cap_state_t;

   // RGB888 {R,G,B} -> RGB332 {R[7:5],G[7:5],B[7:6]}; the pixel selector unpacks the same layout
   function automatic logic [7:0] rgb332(input logic [23:0] rgb);
      return {rgb[23:21], rgb[15:13], rgb[7:6]};
   endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// rtl/fb_addr_gen.sv - registered frame BRAM address: write pointer or vcount*H_ACTIVE+hcount
module fb_addr_gen
   import frame_capture_ctrl_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              rd_en,
   input  logic [10:0]       hcount,
   input  logic [9:0]        vcount,
   output logic [ADDR_W-1:0] addr
);

   localparam logic [31:0] H_BITS = H_ACTIVE;

   logic [ADDR_W-1:0] rd_addr;

   // constant multiply as a sum of shifted vcount terms; for 640 this is (v<<9)+(v<<7)
   function automatic logic [ADDR_W-1:0] mul_h(input logic [9:0] v);
      logic [ADDR_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < 32; i++) begin
         if (H_BITS[i]) acc = acc + (ADDR_W'(v) << i);
      end
      return acc;
   endfunction

   assign rd_addr = mul_h(vcount) + ADDR_W'(hcount);

   // write address has priority; reads update only inside the active area, otherwise hold
   always_ff @(posedge clk) begin
      if (rst) begin
         addr <= '0;
      end else if (wr_en) begin
         addr <= wr_addr;
      end else if (rd_en) begin
         addr <= rd_addr;
      end
   end

endmodule

// File: rtl/frame_capture_ctrl.sv
// rtl/frame_capture_ctrl.sv - single-frame capture sequencer and frozen-frame read addressing
module frame_capture_ctrl
   import frame_capture_ctrl_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture_req,
   input  logic              release_req,
   input  logic [10:0]       hcount,
   input  logic [9:0]        vcount,
   input  logic [23:0]       pixel_in,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [7:0]        bram_din,
   output logic              store_frame,
   output logic              busy,
   output logic              frame_done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
   localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
   localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);

   cap_state_t        state, state_nx;
   logic [ADDR_W-1:0] wr_ptr;
   logic              in_disp, fstart, wr_q, wr_last, rd_en;

   assign in_disp = (hcount < H_LIM) && (vcount < V_LIM);
   assign fstart  = (hcount == 11'd0) && (vcount == 10'd0);
   assign rd_en   = ((state == ST_IDLE) || (state == ST_HOLD)) && in_disp;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // next state and write qualification; release always beats capture
   always_comb begin
      state_nx = state;
      wr_q     = 1'b0;
      wr_last  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (capture_req && !release_req) state_nx = ST_ARM;
         end
         ST_ARM: begin
            if (release_req) begin
               state_nx = ST_IDLE;
            end else if (fstart) begin
               wr_q     = 1'b1;
               state_nx = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (release_req) begin
               state_nx = ST_IDLE;
            end else if (in_disp) begin
               wr_q = 1'b1;
               if (wr_ptr == LAST_ADDR) begin
                  wr_last  = 1'b1;
                  state_nx = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (release_req)      state_nx = ST_IDLE;
            else if (capture_req) state_nx = ST_ARM;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // write pointer: cleared on ARM entry, stops at the last pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
      end else if ((state_nx == ST_ARM) && (state != ST_ARM)) begin
         wr_ptr <= '0;
      end else if (wr_q && !wr_last) begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   // registered outputs other than the address
   always_ff @(posedge clk) begin
      if (rst) begin
         bram_we     <= 1'b0;
         bram_din    <= 8'd0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
         store_frame <= 1'b0;
      end else begin
         bram_we     <= wr_q;
         if (wr_q) bram_din <= rgb332(pixel_in);
         frame_done  <= wr_last;
         busy        <= (state == ST_ARM) || (state == ST_CAPTURE);
         store_frame <= (state == ST_HOLD) && !release_req && !capture_req;
      end
   end

   fb_addr_gen #(
      .H_ACTIVE (H_ACTIVE),
      .ADDR_W   (ADDR_W)
   ) u_addr_gen (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_q),
      .wr_addr (wr_ptr),
      .rd_en   (rd_en),
      .hcount  (hcount),
      .vcount  (vcount),
      .addr    (bram_addr)
   );

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb/tb_frame_capture_ctrl.sv - directed self-checking bench for frame_capture_ctrl
module tb_frame_capture_ctrl;
   import frame_capture_ctrl_pkg::*;

   localparam int TH    = 16;
   localparam int TV    = 8;
   localparam int TOT_H = 20;
   localparam int TOT_V = 10;
   localparam int AW    = 8;
   localparam int FRAME = TOT_H * TOT_V;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          capture_req = 1'b0;
   logic          release_req = 1'b0;
   logic [10:0]   hcount = '0;
   logic [9:0]    vcount = '0;
   logic [23:0]   pixel_in = '0;
   logic          bram_we;
   logic [AW-1:0] bram_addr;
   logic [7:0]    bram_din;
   logic          store_frame, busy, frame_done;

   logic          ag_rd_en = 1'b0;
   logic [10:0]   ag_h = '0;
   logic [9:0]    ag_v = '0;
   logic [17:0]   ag_addr;

   int tests = 0;
   int fails = 0;
   int h, v, hd, vd;
   int wcnt, seq_err, ndone, nstore, done_addr, first_h, first_v, wb;
   logic [7:0]  first_din;
   logic        force_en = 1'b0;
   logic [23:0] force_pix = '0;
   logic [23:0] drv_pix;

   frame_capture_ctrl #(.H_ACTIVE(TH), .V_ACTIVE(TV), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .capture_req(capture_req), .release_req(release_req),
      .hcount(hcount), .vcount(vcount), .pixel_in(pixel_in),
      .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
      .store_frame(store_frame), .busy(busy), .frame_done(frame_done)
   );

   fb_addr_gen u_ag (
      .clk(clk), .rst(rst), .wr_en(1'b0), .wr_addr(18'd0), .rd_en(ag_rd_en),
      .hcount(ag_h), .vcount(ag_v), .addr(ag_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] ramp(input int x, input int y);
      return {8'(x * 13), 8'(y * 29 + 1), 8'(x + y)};
   endfunction

   function automatic logic [7:0] exp332(input logic [23:0] p);
      return {p[23:21], p[15:13], p[7:6]};
   endfunction

   // drive one raster cycle, then sample the registered outputs it produced
   task automatic cyc(input logic creq, input logic rreq);
      hd = h;
      vd = v;
      drv_pix = force_en ? force_pix : ramp(h, v);
      capture_req = creq;
      release_req = rreq;
      hcount = 11'(h);
      vcount = 10'(v);
      pixel_in = drv_pix;
      @(posedge clk);
      #1;
      capture_req = 1'b0;
      release_req = 1'b0;
      if (h == TOT_H - 1) begin
         h = 0;
         v = (v == TOT_V - 1) ? 0 : v + 1;
      end else begin
         h = h + 1;
      end
      if (bram_we === 1'b1) begin
         if (wcnt == 0) begin
            first_h = hd;
            first_v = vd;
            first_din = bram_din;
         end
         if (bram_addr !== AW'(wcnt) || bram_din !== exp332(drv_pix)) seq_err++;
         wcnt++;
      end
      if (frame_done === 1'b1) begin
         ndone++;
         done_addr = int'(bram_addr);
      end
      if (store_frame === 1'b1) nstore++;
   endtask

   task automatic run_to(input int th, input int tv);
      for (int k = 0; k < 3 * FRAME; k++) begin
         if (h == th && v == tv) break;
         cyc(1'b0, 1'b0);
      end
      check("run_to", 32'(h == th && v == tv), 32'd1);
   endtask

   task automatic capture_full();
      run_to(9, 5);
      cyc(1'b1, 1'b0);
      wcnt = 0; seq_err = 0; ndone = 0; nstore = 0;
      for (int k = 0; k < 3 * FRAME; k++) begin
         if (ndone != 0) break;
         cyc(1'b0, 1'b0);
      end
   endtask

   initial begin
      h = 7; v = 3;
      wcnt = 0; seq_err = 0; ndone = 0; nstore = 0; done_addr = -1;
      first_h = -1; first_v = -1; first_din = '0;

      // reset mid-stream, then two idle frames without a request
      rst = 1'b1;
      repeat (3) cyc(1'b0, 1'b0);
      check("rst_outputs", 32'({bram_we, bram_addr, bram_din, store_frame, busy, frame_done}), 32'd0);
      check("rst_state", 32'(dut.state), 32'(ST_IDLE));
      rst = 1'b0;
      wcnt = 0;
      repeat (2 * FRAME) cyc(1'b0, 1'b0);
      check("idle_no_writes", wcnt, 0);
      check("idle_store", nstore, 0);

      // full capture of ramp pixels
      capture_full();
      check("first_wr_h", first_h, 0);
      check("first_wr_v", first_v, 0);
      check("n_writes", wcnt, TH * TV);
      check("wr_sequence", seq_err, 0);
      check("done_count", ndone, 1);
      check("done_addr", done_addr, TH * TV - 1);
      check("store_before_done", nstore, 0);
      cyc(1'b0, 1'b0);
      check("store_after_done", store_frame, 1);
      check("busy_after_done", busy, 0);
      wcnt = 0;
      repeat (FRAME) cyc(1'b0, 1'b0);
      check("hold_no_writes", wcnt, 0);
      check("hold_store", store_frame, 1);

      // read addressing while frozen
      h = 5; v = 2;
      cyc(1'b0, 1'b0);
      check("rd_addr", bram_addr, 2 * TH + 5);
      check("rd_no_we", bram_we, 0);
      h = 17; v = 2;
      cyc(1'b0, 1'b0);
      check("rd_addr_hold", bram_addr, 2 * TH + 5);

      // default-geometry address generator
      ag_rd_en = 1'b1; ag_h = 11'd5; ag_v = 10'd2;
      @(posedge clk); #1;
      check("ag_addr_1285", ag_addr, 1285);
      ag_h = 11'd639; ag_v = 10'd399;
      @(posedge clk); #1;
      check("ag_addr_last", ag_addr, 255999);

      // re-capture from HOLD with a fixed colour at fstart
      run_to(10, 9);
      cyc(1'b1, 1'b0);
      check("store_drop_recap", store_frame, 0);
      wcnt = 0; seq_err = 0; nstore = 0;
      force_en = 1'b1; force_pix = 24'hFF8040;
      for (int k = 0; k < 2 * FRAME; k++) begin
         if (wcnt != 0) break;
         cyc(1'b0, 1'b0);
      end
      force_en = 1'b0;
      check("din_rgb332", first_din, 8'hF1);
      run_to(3, 2);
      cyc(1'b1, 1'b0);
      check("capreq_ignored_state", 32'(dut.state), 32'(ST_CAPTURE));
      check("capreq_ignored_busy", busy, 1);

      // abort mid-capture
      run_to(3, 4);
      wb = wcnt;
      cyc(1'b0, 1'b1);
      repeat (2 * FRAME) cyc(1'b0, 1'b0);
      check("abort_no_writes", wcnt, wb);
      check("abort_store", nstore, 0);
      check("abort_state", 32'(dut.state), 32'(ST_IDLE));
      check("abort_busy", busy, 0);
      check("abort_sequence", seq_err, 0);

      // simultaneous capture+release in HOLD
      capture_full();
      check("cap2_done", ndone, 1);
      cyc(1'b0, 1'b0);
      check("cap2_store", store_frame, 1);
      cyc(1'b1, 1'b1);
      check("both_req_store", store_frame, 0);
      check("both_req_state", 32'(dut.state), 32'(ST_IDLE));
      cyc(1'b0, 1'b0);
      check("both_req_stays_idle", 32'(dut.state), 32'(ST_IDLE));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
